// File: rtl/psum_acc_sequencer.sv
// -----------------------------------------------------------------------------
// psum_acc_sequencer
//
// Initiator side of the SFU accumulate interface. For one job it reads K
// partial-sum rows from psum SRAM, streams them to the SFU framed by
// sfu_acc_o, waits one idle cycle so the SFU can apply ReLU to its
// accumulator, then writes the SFU result into output SRAM.
//
// Job timeline (E0 = edge that accepts start_i, cycle c counts from E0):
//   c = 0..K-1 : RUN   psum read at rd_base + c*rd_stride
//   c = 1..K   :       sfu_acc_o high (row data arrives 1 cycle after read)
//   c = K+1    : WAIT  acc low, SFU applies ReLU
//   c = K+2    : WRITE output SRAM write + done_o
//
// Optional feature macro: PSUM_SEQ_BYPASS_EN
//   Adds bypass_mode_i. In bypass jobs every row is written raw to
//   wr_addr+i in cycle i+1, acc stays low and WAIT is skipped.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start_i         start a job (sampled in IDLE only)
//   num_tiles_i     K rows to accumulate (0 behaves as 1)
//   rd_base_i       first psum read address
//   rd_stride_i     address step between psum rows (wraps mod 2^addr_bw)
//   wr_addr_i       output SRAM write address
//   psum_cen_o      psum SRAM chip enable (active low)
//   psum_addr_o     psum SRAM address
//   psum_data_i     psum SRAM read data (1-cycle latency)
//   sfu_acc_o       SFU accumulate strobe
//   sfu_bypass_o    SFU bypass select
//   sfu_psum_o      row data to SFU (combinational from psum_data_i)
//   sfu_psum_i      SFU result
//   out_cen_o       output SRAM chip enable (active low)
//   out_wen_o       output SRAM write enable (active low)
//   out_addr_o      output SRAM address
//   out_data_o      output SRAM write data (combinational from sfu_psum_i)
//   busy_o          job in flight (cycle after accept through WRITE)
//   done_o          1-cycle pulse with the result write
// -----------------------------------------------------------------------------
module psum_acc_sequencer #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
`ifdef PSUM_SEQ_BYPASS_EN
    input  logic                     bypass_mode_i,
`endif
    input  logic [7:0]               num_tiles_i,
    input  logic [addr_bw-1:0]       rd_base_i,
    input  logic [addr_bw-1:0]       rd_stride_i,
    input  logic [addr_bw-1:0]       wr_addr_i,
    output logic                     psum_cen_o,
    output logic [addr_bw-1:0]       psum_addr_o,
    input  logic [col*psum_bw-1:0]   psum_data_i,
    output logic                     sfu_acc_o,
    output logic                     sfu_bypass_o,
    output logic [col*psum_bw-1:0]   sfu_psum_o,
    input  logic [col*psum_bw-1:0]   sfu_psum_i,
    output logic                     out_cen_o,
    output logic                     out_wen_o,
    output logic [addr_bw-1:0]       out_addr_o,
    output logic [col*psum_bw-1:0]   out_data_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, WRITE} state_t;

    state_t               state_q;
    logic [7:0]           k_q;          // effective row count of the job
    logic [7:0]           cnt_q;        // rows whose read has been issued
    logic [addr_bw-1:0]   stride_q;
    logic [addr_bw-1:0]   wr_q;         // write address (advances in bypass)
    logic                 wait_first_q; // first of the two post-RUN cycles
    logic                 rd_vld_q;
    logic                 psum_cen_q;
    logic [addr_bw-1:0]   psum_addr_q;
    logic                 out_cen_q;
    logic                 out_wen_q;
    logic [addr_bw-1:0]   out_addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 byp_q;

    logic [7:0]           k_eff_d;
    logic                 bypass_d;

    assign k_eff_d = (num_tiles_i == 8'd0) ? 8'd1 : num_tiles_i;

`ifdef PSUM_SEQ_BYPASS_EN
    assign bypass_d = bypass_mode_i;
`else
    assign bypass_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= 8'd0;
            cnt_q        <= 8'd0;
            stride_q     <= '0;
            wr_q         <= '0;
            wait_first_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            psum_cen_q   <= 1'b1;
            psum_addr_q  <= '0;
            out_cen_q    <= 1'b1;
            out_wen_q    <= 1'b1;
            out_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byp_q        <= 1'b0;
        end else begin
            // Read data lands one cycle after the read, so acc is the
            // delayed read strobe. Bypass jobs never accumulate.
            rd_vld_q  <= ~psum_cen_q & ~byp_q;
            out_cen_q <= 1'b1;
            out_wen_q <= 1'b1;
            done_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        k_q         <= k_eff_d;
                        cnt_q       <= 8'd1;
                        stride_q    <= rd_stride_i;
                        wr_q        <= wr_addr_i;
                        psum_cen_q  <= 1'b0;
                        psum_addr_q <= rd_base_i;
                        busy_q      <= 1'b1;
                        byp_q       <= bypass_d;
                    end
                end
                RUN: begin
                    // Bypass: the row read this cycle is written next cycle.
                    if (byp_q) begin
                        out_cen_q  <= 1'b0;
                        out_wen_q  <= 1'b0;
                        out_addr_q <= wr_q;
                        wr_q       <= wr_q + addr_bw'(1);
                    end
                    if (cnt_q == k_q) begin
                        psum_cen_q <= 1'b1;
                        if (byp_q) begin
                            state_q <= WRITE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= WAIT;
                            wait_first_q <= 1'b1;
                        end
                    end else begin
                        psum_addr_q <= psum_addr_q + stride_q;
                        cnt_q       <= cnt_q + 8'd1;
                    end
                end
                WAIT: begin
                    // First WAIT cycle still carries the last acc beat;
                    // the second is the acc-low cycle for the ReLU latch.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else begin
                        state_q    <= WRITE;
                        out_cen_q  <= 1'b0;
                        out_wen_q  <= 1'b0;
                        out_addr_q <= wr_q;
                        done_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    byp_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psum_cen_o   = psum_cen_q;
    assign psum_addr_o  = psum_addr_q;
    assign sfu_acc_o    = rd_vld_q;
    assign sfu_bypass_o = byp_q;
    assign sfu_psum_o   = psum_data_i;
    assign out_cen_o    = out_cen_q;
    assign out_wen_o    = out_wen_q;
    assign out_addr_o   = out_addr_q;
    assign out_data_o   = sfu_psum_i;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Testbench for psum_acc_sequencer: psum SRAM and SFU environment models,
// directed job table plus hand-written corner sequences.
module tb_psum_acc_sequencer;
    localparam int PBW = 16;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int RW  = PBW * COL;

    logic            clk = 1'b0;
    logic            reset, start_i;
    logic [7:0]      num_tiles_i;
    logic [AW-1:0]   rd_base_i, rd_stride_i, wr_addr_i;
    logic            psum_cen_o;
    logic [AW-1:0]   psum_addr_o;
    logic [RW-1:0]   psum_data_i;
    logic            sfu_acc_o, sfu_bypass_o;
    logic [RW-1:0]   sfu_psum_o, sfu_psum_i;
    logic            out_cen_o, out_wen_o;
    logic [AW-1:0]   out_addr_o;
    logic [RW-1:0]   out_data_o;
    logic            busy_o, done_o;

    psum_acc_sequencer #(.psum_bw(PBW), .col(COL), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .num_tiles_i(num_tiles_i),
        .rd_base_i(rd_base_i), .rd_stride_i(rd_stride_i), .wr_addr_i(wr_addr_i),
        .psum_cen_o(psum_cen_o), .psum_addr_o(psum_addr_o), .psum_data_i(psum_data_i),
        .sfu_acc_o(sfu_acc_o), .sfu_bypass_o(sfu_bypass_o), .sfu_psum_o(sfu_psum_o),
        .sfu_psum_i(sfu_psum_i), .out_cen_o(out_cen_o), .out_wen_o(out_wen_o),
        .out_addr_o(out_addr_o), .out_data_o(out_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // psum SRAM: 1-cycle read latency
    logic [RW-1:0] mem [0:2047];
    always @(posedge clk) if (!psum_cen_o) psum_data_i <= mem[psum_addr_o];

    // SFU: reload on first acc beat, accumulate after, ReLU when acc falls
    logic [RW-1:0] sfu_q;
    logic          acc_prev;
    always @(posedge clk) begin
        if (reset) begin
            sfu_q    <= '0;
            acc_prev <= 1'b0;
        end else begin
            acc_prev <= sfu_acc_o;
            for (int l = 0; l < COL; l++) begin
                if (sfu_acc_o)
                    sfu_q[l*PBW +: PBW] <= acc_prev ? sfu_q[l*PBW +: PBW] + sfu_psum_o[l*PBW +: PBW]
                                                    : sfu_psum_o[l*PBW +: PBW];
                else if (acc_prev && sfu_q[l*PBW + PBW-1])
                    sfu_q[l*PBW +: PBW] <= '0;
            end
        end
    end
    assign sfu_psum_i = sfu_bypass_o ? sfu_psum_o : sfu_q;

    typedef struct packed {
        logic [7:0]        k;
        logic [AW-1:0]     base, stride, wr;
        logic [3:0][15:0]  v0;   // lane 0 value of row i
        logic [3:0][15:0]  v1;   // lanes 1..7 value of row i
        logic [15:0]       e0, e1;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int k, base, stride, wr,
                                input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3, e0, e1);
        vec_t v;
        v.k = 8'(k); v.base = AW'(base); v.stride = AW'(stride); v.wr = AW'(wr);
        v.v0[0] = a0; v.v0[1] = a1; v.v0[2] = a2; v.v0[3] = a3;
        v.v1[0] = b0; v.v1[1] = b1; v.v1[2] = b2; v.v1[3] = b3;
        v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    function automatic logic [RW-1:0] row(input logic [15:0] l0, input logic [15:0] lr);
        logic [RW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = (l == 0) ? l0 : lr;
        return r;
    endfunction

    // Runs one job starting at a negedge in IDLE; returns at the negedge of
    // the IDLE cycle after WRITE, so a following call is back-to-back.
    task automatic run_job(input vec_t v, input bit hold_start, output logic [3:0][AW-1:0] seen);
        int keff;
        logic [AW-1:0] a;
        logic rd_ok, acc_ok, wr_ok, busy_ok, ovl_ok, exp_rd, exp_acc, exp_wr;
        logic [AW-1:0] got_addr;
        logic [RW-1:0] got_data;
        keff = (v.k == 8'd0) ? 1 : int'(v.k);
        for (int i = 0; i < keff; i++) begin
            a = v.base + v.stride * AW'(i);
            mem[a] = row(v.v0[i], v.v1[i]);
        end
        seen = '0;
        rd_ok = 1; acc_ok = 1; wr_ok = 1; busy_ok = 1; ovl_ok = 1;
        got_addr = '0; got_data = '0;
        num_tiles_i = v.k; rd_base_i = v.base; rd_stride_i = v.stride; wr_addr_i = v.wr;
        start_i = 1'b1;
        @(negedge clk);
        if (!hold_start) start_i = 1'b0;
        for (int c = 0; c <= keff + 3; c++) begin
            if (c == 2) start_i = 1'b0;
            exp_rd  = (c < keff);
            exp_acc = (c >= 1) && (c <= keff);
            exp_wr  = (c == keff + 2);
            if (psum_cen_o !== !exp_rd) rd_ok = 0;
            if (exp_rd) begin
                a = v.base + v.stride * AW'(c);
                if (psum_addr_o !== a) rd_ok = 0;
                if (c < 4) seen[c] = psum_addr_o;
            end
            if (sfu_acc_o !== exp_acc || sfu_bypass_o !== 1'b0) acc_ok = 0;
            if (out_cen_o !== !exp_wr || out_wen_o !== !exp_wr || done_o !== exp_wr) wr_ok = 0;
            if (exp_wr) begin
                got_addr = out_addr_o;
                got_data = out_data_o;
            end
            if (busy_o !== (c <= keff + 2)) busy_ok = 0;
            if (!psum_cen_o && !out_cen_o) ovl_ok = 0;
            if (c < keff + 3) @(negedge clk);
        end
        chk("rd_seq", RW'(rd_ok), RW'(1));
        chk("acc_frame", RW'(acc_ok), RW'(1));
        chk("wr_timing", RW'(wr_ok), RW'(1));
        chk("busy", RW'(busy_ok), RW'(1));
        chk("no_overlap", RW'(ovl_ok), RW'(1));
        chk("wr_addr", RW'(got_addr), RW'(v.wr));
        chk("wr_data", got_data, row(v.e0, v.e1));
    endtask

    task automatic chk_reset_state();
        chk("rst_cen", RW'({psum_cen_o, out_cen_o, out_wen_o}), RW'(3'b111));
        chk("rst_ctl", RW'({sfu_acc_o, sfu_bypass_o, busy_o, done_o}), RW'(4'b0000));
        chk("rst_addr", RW'({psum_addr_o, out_addr_o}), RW'(0));
    endtask

    vec_t tbl [7];
    logic [3:0][AW-1:0] seen;
    logic wr_seen;

    initial begin
        tbl[0] = mk(3, 10,   1, 100, 16'd5,  16'hFFFE, 16'd4, 16'd0, 16'd5,  16'hFFFE, 16'd4, 16'd0, 16'd7,  16'd7);
        tbl[1] = mk(2, 20,   3, 101, 16'd3,  16'hFFF6, 16'd0, 16'd0, 16'd3,  16'hFFF6, 16'd0, 16'd0, 16'd0,  16'd0);
        tbl[2] = mk(2, 30,   2, 102, 16'd3,  16'd4,    16'd0, 16'd0, 16'hFFFD, 16'hFFFC, 16'd0, 16'd0, 16'd7, 16'd0);
        tbl[3] = mk(0, 40,   5, 103, 16'hFFFF, 16'd0,  16'd0, 16'd0, 16'd9,  16'd0,    16'd0, 16'd0, 16'd0,  16'd9);
        tbl[4] = mk(4, 2046, 1, 104, 16'd1,  16'd2,    16'd3, 16'd4, 16'h7FFF, 16'd1,  16'd0, 16'd0, 16'd10, 16'd0);
        tbl[5] = mk(1, 500,  0, 2047, 16'h1234, 16'd0, 16'd0, 16'd0, 16'h7FFF, 16'd0,  16'd0, 16'd0, 16'h1234, 16'h7FFF);
        tbl[6] = mk(4, 60,   4, 106, 16'h8000, 16'h8000, 16'd1, 16'd0, 16'd100, 16'hFFCE, 16'hFFCE, 16'd1, 16'd1, 16'd1);

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        reset = 1'b1; start_i = 1'b0; num_tiles_i = '0;
        rd_base_i = '0; rd_stride_i = '0; wr_addr_i = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b0;
        @(negedge clk);

        // Table jobs, issued back-to-back
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i], 1'b0, seen);
            if (i == 4) chk("wrap_addrs", RW'(seen), RW'({11'd1, 11'd0, 11'd2047, 11'd2046}));
        end

        // start held high into RUN must be ignored
        run_job(tbl[1], 1'b1, seen);

        // Reset in RUN cycle 2: no write, no done, then a clean job
        num_tiles_i = 8'd3; rd_base_i = 11'd10; rd_stride_i = 11'd1; wr_addr_i = 11'd200;
        start_i = 1'b1;
        @(negedge clk);                 // c=0
        start_i = 1'b0;
        @(negedge clk);                 // c=1
        @(negedge clk);                 // c=2
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state();
        reset = 1'b0;
        wr_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (!out_cen_o || !out_wen_o || done_o || busy_o) wr_seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_no_write", RW'(wr_seen), RW'(0));
        run_job(tbl[0], 1'b0, seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
